// File: rtl/safe_io_disable.sv
// -----------------------------------------------------------------------------
// safe_io_disable
//
// Shutdown gate between the SOPC/motor-controller outputs and the board pins.
// Any synchronised shutdown request immediately forces every gated output bit
// to its safe value. Outputs are released only after all requests have stayed
// clear for DEBOUNCE_CYCLES consecutive cycles. Trips caused by inputs flagged
// in LATCH_MASK additionally need a software rearm pulse before release.
//
// Ports:
//   clk          system clock
//   reset        asynchronous active-high reset (forces safe outputs at once)
//   shutdown     NUM_IN asynchronous shutdown requests, 1 = disable
//   rearm        single-cycle software re-arm pulse (honoured in WAIT_REARM)
//   gpio_in      NUM_IOS functional values from upstream logic
//   gpio_out     NUM_IOS registered gated outputs to the pins
//   tripped      1 whenever gpio_out is forced to SAFE_VALUE
//   trip_cause   sticky record of the inputs responsible for the current trip
//   await_rearm  1 while waiting for a software rearm pulse
// -----------------------------------------------------------------------------
module safe_io_disable #(
  parameter int                 NUM_IN          = 3,
  parameter int                 NUM_IOS         = 55,
  parameter int                 SYNC_STAGES     = 2,
  parameter int                 DEBOUNCE_CYCLES = 50000,
  parameter logic [NUM_IN-1:0]  LATCH_MASK      = {NUM_IN{1'b0}},
  parameter logic [NUM_IOS-1:0] SAFE_VALUE      = {NUM_IOS{1'b0}}
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [NUM_IN-1:0]  shutdown,
  input  logic               rearm,
  input  logic [NUM_IOS-1:0] gpio_in,
  output logic [NUM_IOS-1:0] gpio_out,
  output logic               tripped,
  output logic [NUM_IN-1:0]  trip_cause,
  output logic               await_rearm
);

  localparam int                CNT_W    = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CNT_W-1:0]  CNT_MAX  = CNT_W'(DEBOUNCE_CYCLES);
  localparam logic [CNT_W-1:0]  CNT_ZERO = {CNT_W{1'b0}};
  localparam logic [CNT_W-1:0]  CNT_ONE  = CNT_W'(1);
  localparam logic [NUM_IN-1:0] IN_ZERO  = {NUM_IN{1'b0}};

  typedef enum logic [1:0] {
    ST_RUN        = 2'd0,
    ST_TRIP       = 2'd1,
    ST_WAIT_REARM = 2'd2
  } state_t;

  logic [SYNC_STAGES-1:0][NUM_IN-1:0] sync_r;
  logic [NUM_IN-1:0]                  sync_out_s;
  logic                               any_s;

  state_t             state_r;
  state_t             state_next_s;
  logic [CNT_W-1:0]   cnt_r;
  logic [CNT_W-1:0]   cnt_next_s;
  logic [NUM_IN-1:0]  trip_cause_r;
  logic [NUM_IN-1:0]  cause_next_s;

  logic [NUM_IOS-1:0] gpio_out_r;
  logic [NUM_IOS-1:0] gpio_next_s;
  logic               tripped_r;
  logic               tripped_next_s;
  logic               await_rearm_r;
  logic               await_next_s;

  // Shutdown synchroniser: shift chain per request bit, oldest stage is used.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync_r <= {(SYNC_STAGES * NUM_IN){1'b0}};
    end else begin
      sync_r <= {sync_r[SYNC_STAGES-2:0], shutdown};
    end
  end

  assign sync_out_s = sync_r[SYNC_STAGES-1];
  assign any_s      = |sync_out_s;

  // State, debounce counter and registered outputs; reset comes up tripped.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r       <= ST_TRIP;
      cnt_r         <= CNT_ZERO;
      trip_cause_r  <= IN_ZERO;
      gpio_out_r    <= SAFE_VALUE;
      tripped_r     <= 1'b1;
      await_rearm_r <= 1'b0;
    end else begin
      state_r       <= state_next_s;
      cnt_r         <= cnt_next_s;
      trip_cause_r  <= cause_next_s;
      gpio_out_r    <= gpio_next_s;
      tripped_r     <= tripped_next_s;
      await_rearm_r <= await_next_s;
    end
  end

  // Next-state logic: trips are immediate, release waits for the debounce window.
  always_comb begin
    state_next_s = state_r;
    cnt_next_s   = cnt_r;
    cause_next_s = trip_cause_r;
    case (state_r)
      ST_RUN: begin
        if (any_s) begin
          state_next_s = ST_TRIP;
          cnt_next_s   = CNT_ZERO;
          cause_next_s = sync_out_s;
        end else begin
          cnt_next_s   = CNT_ZERO;
          cause_next_s = IN_ZERO;
        end
      end
      ST_TRIP: begin
        // Later-asserting requests accumulate into the cause record.
        cause_next_s = trip_cause_r | sync_out_s;
        if (any_s) begin
          cnt_next_s = CNT_ZERO;
        end else if (cnt_r == CNT_MAX) begin
          cnt_next_s = CNT_ZERO;
          if ((trip_cause_r & LATCH_MASK) != IN_ZERO) begin
            state_next_s = ST_WAIT_REARM;
          end else begin
            state_next_s = ST_RUN;
            cause_next_s = IN_ZERO;
          end
        end else begin
          cnt_next_s = cnt_r + CNT_ONE;
        end
      end
      ST_WAIT_REARM: begin
        // A fresh request outranks a rearm arriving in the same cycle.
        if (any_s) begin
          state_next_s = ST_TRIP;
          cnt_next_s   = CNT_ZERO;
          cause_next_s = trip_cause_r | sync_out_s;
        end else if (rearm) begin
          state_next_s = ST_RUN;
          cnt_next_s   = CNT_ZERO;
          cause_next_s = IN_ZERO;
        end else begin
          state_next_s = ST_WAIT_REARM;
        end
      end
      default: begin
        state_next_s = ST_TRIP;
        cnt_next_s   = CNT_ZERO;
        cause_next_s = trip_cause_r | sync_out_s;
      end
    endcase
  end

  // Output logic: decoded from the next state so the registered outputs line up
  // with the state they describe (trip and release take effect on the same edge).
  always_comb begin
    gpio_next_s    = SAFE_VALUE;
    tripped_next_s = 1'b1;
    await_next_s   = 1'b0;
    case (state_next_s)
      ST_RUN: begin
        gpio_next_s    = gpio_in;
        tripped_next_s = 1'b0;
      end
      ST_TRIP: begin
        gpio_next_s    = SAFE_VALUE;
        tripped_next_s = 1'b1;
      end
      ST_WAIT_REARM: begin
        gpio_next_s    = SAFE_VALUE;
        tripped_next_s = 1'b1;
        await_next_s   = 1'b1;
      end
      default: begin
        gpio_next_s    = SAFE_VALUE;
        tripped_next_s = 1'b1;
        await_next_s   = 1'b0;
      end
    endcase
  end

  assign gpio_out    = gpio_out_r;
  assign tripped     = tripped_r;
  assign trip_cause  = trip_cause_r;
  assign await_rearm = await_rearm_r;

endmodule

// File: tb/tb_safe_io_disable.sv
// -----------------------------------------------------------------------------
// tb_safe_io_disable
//
// Directed bench for safe_io_disable with DEBOUNCE_CYCLES=8, NUM_IN=3,
// NUM_IOS=8, LATCH_MASK=3'b100, SAFE_VALUE=8'h00, SYNC_STAGES=2.
// Inputs change 1 ns after a rising edge; outputs are checked at that point.
// A shutdown input last sampled high at edge X releases at edge X+11
// (2 sync stages, 8 clear counts, 1 release edge).
// -----------------------------------------------------------------------------
module tb_safe_io_disable;

  logic       clk;
  logic       reset;
  logic [2:0] shutdown;
  logic       rearm;
  logic [7:0] gpio_in;
  logic [7:0] gpio_out;
  logic       tripped;
  logic [2:0] trip_cause;
  logic       await_rearm;

  int total;
  int bad;

  safe_io_disable #(
    .NUM_IN          (3),
    .NUM_IOS         (8),
    .SYNC_STAGES     (2),
    .DEBOUNCE_CYCLES (8),
    .LATCH_MASK      (3'b100),
    .SAFE_VALUE      (8'h00)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .shutdown    (shutdown),
    .rearm       (rearm),
    .gpio_in     (gpio_in),
    .gpio_out    (gpio_out),
    .tripped     (tripped),
    .trip_cause  (trip_cause),
    .await_rearm (await_rearm)
  );

  // 100 MHz bench clock, rising edges at 5, 15, 25 ...
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  initial begin
    total    = 0;
    bad      = 0;
    reset    = 1'b1;
    shutdown = 3'b000;
    rearm    = 1'b0;
    gpio_in  = 8'hA5;

    // Reset state
    #12;
    check("rst_gpio",   32'(gpio_out),    32'h00);
    check("rst_trip",   32'(tripped),     32'h1);
    check("rst_cause",  32'(trip_cause),  32'h0);
    check("rst_await",  32'(await_rearm), 32'h0);
    reset = 1'b0;

    // Release out of reset after 8 clear cycles plus one edge
    tick(8);
    check("boot_hold_gpio", 32'(gpio_out), 32'h00);
    check("boot_hold_trip", 32'(tripped),  32'h1);
    tick(1);
    check("boot_rel_gpio",  32'(gpio_out), 32'hA5);
    check("boot_rel_trip",  32'(tripped),  32'h0);

    // RUN passthrough with one-cycle latency
    gpio_in = 8'h3C;
    tick(1);
    check("run_pass", 32'(gpio_out), 32'h3C);

    // shutdown[0] high for 3 edges
    shutdown = 3'b001;
    tick(2);
    check("trip0_not_yet", 32'(gpio_out), 32'h3C);
    tick(1);
    check("trip0_gpio",  32'(gpio_out),   32'h00);
    check("trip0_trip",  32'(tripped),    32'h1);
    check("trip0_cause", 32'(trip_cause), 32'h1);
    shutdown = 3'b000;
    tick(10);
    check("trip0_hold", 32'(gpio_out), 32'h00);
    tick(1);
    check("trip0_rel_gpio",  32'(gpio_out),   32'h3C);
    check("trip0_rel_cause", 32'(trip_cause), 32'h0);
    check("trip0_rel_trip",  32'(tripped),    32'h0);

    // TRIP, then shutdown[1] pulse at clear-count 5 restarts the window
    shutdown = 3'b001;
    tick(3);
    check("retrig_trip", 32'(tripped), 32'h1);
    shutdown = 3'b000;
    tick(7);
    shutdown = 3'b010;
    tick(1);
    shutdown = 3'b000;
    tick(3);
    check("retrig_old_pt_trip", 32'(tripped),    32'h1);
    check("retrig_cause",       32'(trip_cause), 32'h3);
    tick(7);
    check("retrig_hold", 32'(gpio_out), 32'h00);
    tick(1);
    check("retrig_rel_gpio",  32'(gpio_out),   32'h3C);
    check("retrig_rel_cause", 32'(trip_cause), 32'h0);

    // Latched input 2: release waits for rearm
    gpio_in  = 8'h5A;
    shutdown = 3'b100;
    tick(1);
    shutdown = 3'b000;
    tick(2);
    check("latch_trip",  32'(tripped),    32'h1);
    check("latch_cause", 32'(trip_cause), 32'h4);
    tick(8);
    check("latch_pre_await", 32'(await_rearm), 32'h0);
    tick(1);
    check("latch_await",      32'(await_rearm), 32'h1);
    check("latch_await_gpio", 32'(gpio_out),    32'h00);
    check("latch_await_trip", 32'(tripped),     32'h1);
    tick(3);
    check("latch_still_await", 32'(await_rearm), 32'h1);
    rearm = 1'b1;
    tick(1);
    rearm = 1'b0;
    check("rearm_gpio",  32'(gpio_out),    32'h5A);
    check("rearm_await", 32'(await_rearm), 32'h0);
    check("rearm_trip",  32'(tripped),     32'h0);
    check("rearm_cause", 32'(trip_cause),  32'h0);

    // WAIT_REARM: shutdown beats a same-cycle rearm
    shutdown = 3'b100;
    tick(1);
    shutdown = 3'b000;
    tick(11);
    check("wait2_await", 32'(await_rearm), 32'h1);
    shutdown = 3'b001;
    tick(2);
    check("wait2_sync_await", 32'(await_rearm), 32'h1);
    rearm = 1'b1;
    tick(1);
    rearm    = 1'b0;
    shutdown = 3'b000;
    check("prio_trip",  32'(tripped),     32'h1);
    check("prio_await", 32'(await_rearm), 32'h0);
    check("prio_gpio",  32'(gpio_out),    32'h00);
    check("prio_cause", 32'(trip_cause),  32'h5);
    // rearm during TRIP has no effect
    rearm = 1'b1;
    tick(1);
    rearm = 1'b0;
    check("trip_rearm_ign", 32'(tripped), 32'h1);
    tick(10);
    check("prio_rel_await", 32'(await_rearm), 32'h1);
    rearm = 1'b1;
    tick(1);
    rearm = 1'b0;
    check("prio_rel_gpio", 32'(gpio_out), 32'h5A);

    // Asynchronous reset while in RUN
    gpio_in = 8'hFF;
    tick(1);
    check("pre_arst_gpio", 32'(gpio_out), 32'hFF);
    #2;
    reset = 1'b1;
    #1;
    check("arst_gpio",  32'(gpio_out),   32'h00);
    check("arst_trip",  32'(tripped),    32'h1);
    check("arst_cause", 32'(trip_cause), 32'h0);
    tick(1);
    reset = 1'b0;
    tick(8);
    check("arst_hold", 32'(gpio_out), 32'h00);
    tick(1);
    check("arst_rel_gpio", 32'(gpio_out), 32'hFF);
    check("arst_rel_trip", 32'(tripped),  32'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
